// File: rtl/vx_mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_mem_arb_pkg                                                             |
// | Shared types and tag-index helpers for the memory request arbiter.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vx_mem_arb_pkg;

  localparam int unsigned ARB_DEF_NUM_REQS     = 4;
  localparam int unsigned ARB_DEF_LOG_NUM_REQS = $clog2(ARB_DEF_NUM_REQS);
  localparam int unsigned TAG_IDX_LSB          = 0;
  localparam int unsigned TAG_MAX_WIDTH        = 64;

  typedef logic [ARB_DEF_LOG_NUM_REQS-1:0] arb_idx_t;

  // Requester index lives in the low bits of the downstream tag.
  function automatic int unsigned tag_to_idx(input logic [TAG_MAX_WIDTH-1:0] tag,
                                             input int unsigned log_n);
    logic [TAG_MAX_WIDTH-1:0] mask;
    logic [TAG_MAX_WIDTH-1:0] field;
    mask  = (TAG_MAX_WIDTH'(1) << log_n) - TAG_MAX_WIDTH'(1);
    field = (tag >> TAG_IDX_LSB) & mask;
    return int'(field[31:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_rr_arbiter                                                              |
// | Round-robin arbiter; pointer moves past the winner only when en_i is high. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vx_rr_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int LOG_NUM_REQS = $clog2(NUM_REQS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     req_i,
  input  logic                    en_i,
  output logic [NUM_REQS-1:0]     grant_onehot_o,
  output logic [LOG_NUM_REQS-1:0] grant_idx_o,
  output logic                    grant_valid_o
);

  logic [LOG_NUM_REQS-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int   j;
    logic found;
    j              = 0;
    found          = 1'b0;
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQS) j = j - NUM_REQS;
      if (!found && req_i[j]) begin
        found          = 1'b1;
        grant_idx_o    = LOG_NUM_REQS'(j);
        grant_onehot_o[j] = 1'b1;
      end
    end
    grant_valid_o = found;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (en_i && grant_valid_o) begin
      rr_ptr_d = (grant_idx_o == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/vx_mem_req_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_mem_req_arb                                                             |
// | N:1 round-robin memory request arbiter with tag-indexed response routing.  |
// | VX_MEM_ARB_OUT_BUF_EN adds a 2-entry output skid buffer (+1 cycle).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vx_mem_req_arb
  import vx_mem_arb_pkg::*;
#(
  parameter int NUM_REQS      = 4,
  parameter int DATA_WIDTH    = 512,
  parameter int DATA_SIZE     = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH    = 26,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int LOG_NUM_REQS  = $clog2(NUM_REQS),
  parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_in_valid,
  input  logic [NUM_REQS-1:0]              req_in_rw,
  input  logic [NUM_REQS*DATA_SIZE-1:0]    req_in_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_in_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_in_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_in_tag,
  output logic [NUM_REQS-1:0]              req_in_ready,
  output logic                             req_out_valid,
  output logic                             req_out_rw,
  output logic [DATA_SIZE-1:0]             req_out_byteen,
  output logic [ADDR_WIDTH-1:0]            req_out_addr,
  output logic [DATA_WIDTH-1:0]            req_out_data,
  output logic [TAG_OUT_WIDTH-1:0]         req_out_tag,
  input  logic                             req_out_ready,
  input  logic                             rsp_in_valid,
  input  logic [DATA_WIDTH-1:0]            rsp_in_data,
  input  logic [TAG_OUT_WIDTH-1:0]         rsp_in_tag,
  output logic                             rsp_in_ready,
  output logic [NUM_REQS-1:0]              rsp_out_valid,
  output logic [NUM_REQS*DATA_WIDTH-1:0]   rsp_out_data,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0] rsp_out_tag,
  input  logic [NUM_REQS-1:0]              rsp_out_ready
);

  generate
    if (NUM_REQS < 2) begin : g_num_reqs_check
      $error("vx_mem_req_arb: NUM_REQS must be >= 2");
    end
  endgenerate

  typedef struct packed {
    logic                     rw;
    logic [DATA_SIZE-1:0]     byteen;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } req_pkt_t;

  logic [NUM_REQS-1:0]     arb_req;
  logic [NUM_REQS-1:0]     arb_onehot;
  logic [LOG_NUM_REQS-1:0] arb_idx;
  logic                    arb_valid;
  logic                    arb_en;
  req_pkt_t                sel_pkt;
  req_pkt_t                out_pkt;

  vx_rr_arbiter #(
    .NUM_REQS     (NUM_REQS),
    .LOG_NUM_REQS (LOG_NUM_REQS)
  ) u_arb (
    .clk            (clk),
    .reset          (reset),
    .req_i          (arb_req),
    .en_i           (arb_en),
    .grant_onehot_o (arb_onehot),
    .grant_idx_o    (arb_idx),
    .grant_valid_o  (arb_valid)
  );

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (arb_onehot[i]) begin
        sel_pkt.rw     = req_in_rw[i];
        sel_pkt.byteen = req_in_byteen[i*DATA_SIZE +: DATA_SIZE];
        sel_pkt.addr   = req_in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_pkt.data   = req_in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_pkt.tag    = {req_in_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH], arb_idx};
      end
    end
  end

`ifdef VX_MEM_ARB_OUT_BUF_EN
  req_pkt_t   buf_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push_rdy, push, pop;

  // Upstream readiness looks only at occupancy, breaking the ready path.
  assign push_rdy      = (cnt_q != 2'd2) && !reset;
  assign push          = arb_valid && push_rdy;
  assign pop           = req_out_valid && req_out_ready;
  assign arb_req       = req_in_valid & {NUM_REQS{!reset}};
  assign arb_en        = push;
  assign req_in_ready  = arb_onehot & {NUM_REQS{push_rdy}};
  assign req_out_valid = (cnt_q != 2'd0) && !reset;
  assign out_pkt       = buf_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
    if (push) buf_q[wr_ptr_q] <= sel_pkt;
  end
`else
  logic                    lock_q, lock_d;
  logic [LOG_NUM_REQS-1:0] lock_idx_q, lock_idx_d;

  // A stalled grant is pinned by presenting only the locked requester.
  assign arb_req = (lock_q ? (req_in_valid & (NUM_REQS'(1) << lock_idx_q)) : req_in_valid)
                   & {NUM_REQS{!reset}};
  assign arb_en        = arb_valid && req_out_ready;
  assign req_in_ready  = arb_onehot & {NUM_REQS{req_out_ready}};
  assign req_out_valid = arb_valid;
  assign out_pkt       = sel_pkt;

  always_comb begin
    lock_d     = arb_valid && !req_out_ready;
    lock_idx_d = arb_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`endif

  assign req_out_rw     = out_pkt.rw;
  assign req_out_byteen = out_pkt.byteen;
  assign req_out_addr   = out_pkt.addr;
  assign req_out_data   = out_pkt.data;
  assign req_out_tag    = out_pkt.tag;

  int unsigned rsp_idx;

  // Out-of-range indices match no requester and are accepted and dropped.
  always_comb begin
    rsp_idx       = tag_to_idx(TAG_MAX_WIDTH'(rsp_in_tag), LOG_NUM_REQS);
    rsp_out_valid = '0;
    rsp_in_ready  = !reset;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (rsp_idx == i) begin
        rsp_out_valid[i] = rsp_in_valid && !reset;
        rsp_in_ready     = rsp_out_ready[i] && !reset;
      end
    end
  end

  assign rsp_out_data = {NUM_REQS{rsp_in_data}};
  assign rsp_out_tag  = {NUM_REQS{rsp_in_tag[TAG_OUT_WIDTH-1:LOG_NUM_REQS]}};

endmodule
`default_nettype wire

// File: tb/tb_vx_mem_req_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vx_mem_req_arb                                                          |
// | Self-checking bench: directed scenarios plus randomized model comparison.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vx_mem_req_arb;
  import vx_mem_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int DS = DW / 8;
  localparam int AW = 26;
  localparam int TI = 8;
  localparam int LG = 2;
  localparam int TO = TI + LG;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req_in_valid, req_in_rw, req_in_ready;
  logic [N*DS-1:0] req_in_byteen;
  logic [N*AW-1:0] req_in_addr;
  logic [N*DW-1:0] req_in_data;
  logic [N*TI-1:0] req_in_tag;
  logic            req_out_valid, req_out_rw, req_out_ready;
  logic [DS-1:0]   req_out_byteen;
  logic [AW-1:0]   req_out_addr;
  logic [DW-1:0]   req_out_data;
  logic [TO-1:0]   req_out_tag;
  logic            rsp_in_valid, rsp_in_ready;
  logic [DW-1:0]   rsp_in_data;
  logic [TO-1:0]   rsp_in_tag;
  logic [N-1:0]    rsp_out_valid, rsp_out_ready;
  logic [N*DW-1:0] rsp_out_data;
  logic [N*TI-1:0] rsp_out_tag;

  // Requester-side state: each requester holds its payload until accepted.
  logic [N-1:0]  r_vld, r_rw;
  logic [DS-1:0] r_be   [N];
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_data [N];
  logic [TI-1:0] r_tag  [N];

  always_comb begin
    req_in_valid  = r_vld;
    req_in_rw     = r_rw;
    req_in_byteen = '0;
    req_in_addr   = '0;
    req_in_data   = '0;
    req_in_tag    = '0;
    for (int i = 0; i < N; i++) begin
      req_in_byteen[i*DS +: DS] = r_be[i];
      req_in_addr[i*AW +: AW]   = r_addr[i];
      req_in_data[i*DW +: DW]   = r_data[i];
      req_in_tag[i*TI +: TI]    = r_tag[i];
    end
  end

  vx_mem_req_arb #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TI)
  ) dut (
    .clk(clk), .reset(reset),
    .req_in_valid(req_in_valid), .req_in_rw(req_in_rw), .req_in_byteen(req_in_byteen),
    .req_in_addr(req_in_addr), .req_in_data(req_in_data), .req_in_tag(req_in_tag),
    .req_in_ready(req_in_ready),
    .req_out_valid(req_out_valid), .req_out_rw(req_out_rw), .req_out_byteen(req_out_byteen),
    .req_out_addr(req_out_addr), .req_out_data(req_out_data), .req_out_tag(req_out_tag),
    .req_out_ready(req_out_ready),
    .rsp_in_valid(rsp_in_valid), .rsp_in_data(rsp_in_data), .rsp_in_tag(rsp_in_tag),
    .rsp_in_ready(rsp_in_ready),
    .rsp_out_valid(rsp_out_valid), .rsp_out_data(rsp_out_data), .rsp_out_tag(rsp_out_tag),
    .rsp_out_ready(rsp_out_ready)
  );

  typedef struct packed {
    logic          rw;
    logic [DS-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TO-1:0] tag;
  } pkt_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ptr;
  int   m_lock;
  pkt_t m_q [$];

  function automatic pkt_t req_pkt(input int i);
    arb_idx_t idx;
    idx = arb_idx_t'(i);
    return {r_rw[i], r_be[i], r_addr[i], r_data[i], r_tag[i], idx};
  endfunction

  function automatic pkt_t out_pkt();
    return {req_out_rw, req_out_byteen, req_out_addr, req_out_data, req_out_tag};
  endfunction

  // Round-robin rule: first valid index at or after ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic new_payload(input int i);
    r_rw[i]   = 1'($urandom);
    r_be[i]   = DS'($urandom);
    r_addr[i] = AW'($urandom);
    r_data[i] = {$urandom, $urandom};
    r_tag[i]  = TI'($urandom);
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) new_payload(i);
    r_vld = '0; reset = 1'b1; req_out_ready = 1'b1;
    rsp_in_valid = 1'b0; rsp_in_tag = '0; rsp_in_data = '0; rsp_out_ready = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (req_out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", c, req_out_valid);
      end
      n_tests++;
      if (req_in_ready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=0000", c, req_in_ready);
      end
      n_tests++;
      if (rsp_out_valid !== 4'b0000) begin
        n_fail++; $display("FAIL reset_rsp_valid cyc=%0d got=%b exp=0000", c, rsp_out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    int exp;
    r_vld = '1; req_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp = k % N;
      @(negedge clk);
      n_tests++;
      if (req_out_valid !== 1'b1 || out_pkt() !== req_pkt(exp)) begin
        n_fail++;
        $display("FAIL rr_grant k=%0d got_tag=%h exp_tag=%h", k, req_out_tag, {r_tag[exp], LG'(exp)});
      end
      n_tests++;
      if (req_in_ready !== (N'(1) << exp)) begin
        n_fail++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_in_ready, N'(1) << exp);
      end
      @(posedge clk); #1;
      new_payload(exp);
    end
    r_vld = '0;
  endtask

  task automatic test_lock();
    pkt_t held;
    r_vld = 4'b1000; req_out_ready = 1'b1;
    @(posedge clk); #1;
    r_vld = 4'b0100; req_out_ready = 1'b0;
    held = req_pkt(2);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin new_payload(0); r_vld[0] = 1'b1; end
      @(negedge clk);
      n_tests++;
      if (req_out_valid !== 1'b1 || out_pkt() !== held || req_in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL lock_hold c=%0d got_tag=%h exp_tag=%h ready=%b", c, req_out_tag, held.tag, req_in_ready);
      end
      @(posedge clk); #1;
    end
    req_out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_in_ready !== 4'b0100 || out_pkt() !== held) begin
      n_fail++; $display("FAIL lock_accept got=%b exp=0100", req_in_ready);
    end
    @(posedge clk); #1;
    r_vld[2] = 1'b0; new_payload(1); r_vld[1] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_in_ready !== 4'b0001 || req_out_tag[LG-1:0] !== 2'd0) begin
      n_fail++; $display("FAIL lock_next got=%b exp=0001 idx=%0d", req_in_ready, req_out_tag[LG-1:0]);
    end
    @(posedge clk); #1;
    r_vld = '0;
  endtask

  task automatic test_response();
    int            idx;
    logic [TI-1:0] up;
    rsp_in_valid = 1'b1; rsp_in_tag = 10'h0B3; rsp_in_data = {$urandom, $urandom};
    rsp_out_ready = 4'b1000;
    @(negedge clk);
    n_tests++;
    if (rsp_out_valid !== 4'b1000 || rsp_out_tag[3*TI +: TI] !== 8'h2C || rsp_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_route got v=%b t=%h r=%b exp v=1000 t=2c r=1", rsp_out_valid, rsp_out_tag[3*TI +: TI], rsp_in_ready);
    end
    @(posedge clk); #1;
    rsp_out_ready = 4'b0111;
    @(negedge clk);
    n_tests++;
    if (rsp_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rsp_backpressure got=%b exp=0", rsp_in_ready);
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      idx = int'($urandom_range(0, N - 1));
      up  = TI'($urandom);
      rsp_in_valid  = 1'($urandom);
      rsp_in_tag    = {up, LG'(idx)};
      rsp_in_data   = {$urandom, $urandom};
      rsp_out_ready = N'($urandom);
      @(negedge clk);
      n_tests++;
      if (rsp_out_valid !== (rsp_in_valid ? (N'(1) << idx) : N'(0)) ||
          rsp_in_ready !== rsp_out_ready[idx] ||
          rsp_out_data !== {N{rsp_in_data}} || rsp_out_tag !== {N{up}}) begin
        n_fail++;
        $display("FAIL rsp_random k=%0d idx=%0d got v=%b r=%b", k, idx, rsp_out_valid, rsp_in_ready);
      end
    end
    @(posedge clk); #1;
    rsp_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    r_vld = 4'b0100; req_out_ready = 1'b1;
    @(posedge clk); #1;
    new_payload(1); r_vld = 4'b0010; req_out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (req_out_valid !== 1'b0 || req_in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid got v=%b r=%b exp v=0 r=0000", req_out_valid, req_in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0; new_payload(3); r_vld = 4'b1010; req_out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_out_valid !== 1'b1 || out_pkt() !== req_pkt(1)) begin
      n_fail++; $display("FAIL reset_regrant got_idx=%0d exp_idx=1", req_out_tag[LG-1:0]);
    end
    @(posedge clk); #1;
    r_vld = '0;
  endtask

  task automatic test_random();
    int         g, xfer, n_out, cyc;
    logic [N-1:0] er;
    reset = 1'b1; r_vld = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ptr = 0; m_lock = -1; m_q.delete();
    n_out = 0; cyc = 0;
    while ((cyc < 300 || n_out < 100) && cyc < 2000) begin
      for (int i = 0; i < N; i++) begin
        if (!r_vld[i] && ($urandom % 3 == 0)) begin new_payload(i); r_vld[i] = 1'b1; end
      end
`ifdef VX_MEM_ARB_OUT_BUF_EN
      req_out_ready = cyc[0];
`else
      req_out_ready = ($urandom % 4) != 0;
`endif
      xfer = -1;
      @(negedge clk);
`ifdef VX_MEM_ARB_OUT_BUF_EN
      g  = rr_pick(r_vld, m_ptr);
      er = (g >= 0 && m_q.size() < 2) ? (N'(1) << g) : N'(0);
      n_tests++;
      if (req_in_ready !== er) begin
        n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_in_ready, er);
      end
      n_tests++;
      if (req_out_valid !== (m_q.size() > 0) || (m_q.size() > 0 && out_pkt() !== m_q[0])) begin
        n_fail++; $display("FAIL rand_out cyc=%0d got_v=%b got_tag=%h", cyc, req_out_valid, req_out_tag);
      end
      if (m_q.size() > 0 && req_out_ready) begin
        void'(m_q.pop_front()); n_out++;
      end
      if (er != '0) begin
        m_q.push_back(req_pkt(g)); m_ptr = (g + 1) % N; xfer = g;
      end
`else
      g  = (m_lock >= 0) ? m_lock : rr_pick(r_vld, m_ptr);
      er = (g >= 0 && req_out_ready) ? (N'(1) << g) : N'(0);
      n_tests++;
      if (req_in_ready !== er || req_out_valid !== (g >= 0)) begin
        n_fail++; $display("FAIL rand_grant cyc=%0d got=%b/%b exp=%b/%b", cyc, req_in_ready, req_out_valid, er, g >= 0);
      end
      if (g >= 0) begin
        n_tests++;
        if (out_pkt() !== req_pkt(g)) begin
          n_fail++; $display("FAIL rand_payload cyc=%0d got_tag=%h exp_idx=%0d", cyc, req_out_tag, g);
        end
        if (req_out_ready) begin
          m_ptr = (g + 1) % N; m_lock = -1; xfer = g; n_out++;
        end else begin
          m_lock = g;
        end
      end else begin
        m_lock = -1;
      end
`endif
      @(posedge clk); #1;
      if (xfer >= 0) r_vld[xfer] = 1'b0;
      cyc++;
    end
    n_tests++;
    if (n_out < 100) begin
      n_fail++; $display("FAIL rand_progress got=%0d exp>=100 transfers", n_out);
    end
    r_vld = '0;
  endtask

  initial begin
    test_reset();
`ifndef VX_MEM_ARB_OUT_BUF_EN
    test_round_robin();
    test_lock();
    test_reset_mid();
`endif
    test_response();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vx_mem_req_arb.md
Name: vx_mem_req_arb

Overview:
- Shares one downstream memory request port (valid/rw/byteen/addr/data/tag/ready) between NUM_REQS upstream requesters using round-robin arbitration.
- Appends the winning requester index to the outgoing tag.
- Routes returning responses back to the originating requester by decoding that index from the response tag.
- Sits between per-core or per-cache-bank request sources and the shared memory/L2 interface.

Parameters:
- NUM_REQS, 4: number of upstream requesters; must be ≥2. NUM_REQS=1 is a compile-time error.
- DATA_WIDTH, 512: request and response data width in bits.
- DATA_SIZE, DATA_WIDTH/8: byte-enable width.
- ADDR_WIDTH, 26: request address width.
- TAG_IN_WIDTH, 8: upstream tag width.
- LOG_NUM_REQS, clog2(NUM_REQS): index width.
- TAG_OUT_WIDTH, TAG_IN_WIDTH+LOG_NUM_REQS: downstream tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_in_valid  in  NUM_REQS  per-requester request valid
- req_in_rw  in  NUM_REQS  1=write
- req_in_byteen  in  NUM_REQS*DATA_SIZE  byte enables
- req_in_addr  in  NUM_REQS*ADDR_WIDTH  addresses
- req_in_data  in  NUM_REQS*DATA_WIDTH  write data
- req_in_tag  in  NUM_REQS*TAG_IN_WIDTH  tags
- req_in_ready  out  NUM_REQS  per-requester accept
- req_out_valid  out  1  downstream request valid
- req_out_rw  out  1
- req_out_byteen  out  DATA_SIZE
- req_out_addr  out  ADDR_WIDTH
- req_out_data  out  DATA_WIDTH
- req_out_tag  out  TAG_OUT_WIDTH  {req_in_tag, index}; index in LSBs
- req_out_ready  in  1  downstream accept
- rsp_in_valid  in  1  downstream response valid
- rsp_in_data  in  DATA_WIDTH
- rsp_in_tag  in  TAG_OUT_WIDTH
- rsp_in_ready  out  1
- rsp_out_valid  out  NUM_REQS  one-hot response valid
- rsp_out_data  out  NUM_REQS*DATA_WIDTH  broadcast data
- rsp_out_tag  out  NUM_REQS*TAG_IN_WIDTH  upper tag bits, broadcast
- rsp_out_ready  in  NUM_REQS

Behaviour:
- Handshake:
  - A transfer occurs when valid && ready are both high on a rising clk.
  - Once asserted, valid must not drop and payload must not change until the transfer. This holds for the upstream requesters and is guaranteed by this block on req_out.
- Arbitration:
  - Round-robin pointer rr_ptr (LOG_NUM_REQS bits), reset to 0.
  - Grant goes to the first valid requester at index ≥ rr_ptr, wrapping modulo NUM_REQS.
  - rr_ptr advances to grant+1 (mod NUM_REQS) only on a completed downstream-side transfer, never on a stall.
  - While req_out_valid is high and not accepted, the grant is locked; a new higher-priority arrival does not change it. A lock register holds the grant index.
- req_in_ready:
  - Only the granted index sees ready, and only when the output stage can accept.
  - All others are 0.
  - At most one req_in_ready bit is high per cycle.
- Latency:
  - Request path without the optional feature: combinational, 0 cycles.
  - Response path: always combinational, 0 cycles.
- Response routing:
  - idx = rsp_in_tag[LOG_NUM_REQS-1:0].
  - rsp_out_valid[idx] = rsp_in_valid.
  - rsp_in_ready = rsp_out_ready[idx].
  - Out-of-range idx (NUM_REQS not a power of 2): rsp_in_ready=1 and the response is dropped.
- Reset values:
  - req_out_valid=0, all req_in_ready=0, rsp_out_valid=0.
  - rr_ptr=0; lock cleared.
  - Reset mid-transfer discards any pending request; requesters must re-present.
- Simultaneous events: a request grant and a response delivery in the same cycle are independent; no interaction.
- All-invalid inputs: req_out_valid=0 and rr_ptr holds.

Optional Feature:
- Macro: VX_MEM_ARB_OUT_BUF_EN.
- Defined:
  - A 2-entry skid buffer sits on the req_out path, adding 1 cycle of latency.
  - req_in_ready depends only on buffer occupancy (<2 entries), not combinationally on req_out_ready.
  - Sustains 1 transfer/cycle.
  - Buffer empties on reset.
  - Grant lock is unnecessary, so the pointer advances on the upstream-side transfer.
- Undefined: combinational path as described above.

Decomposition:
- Package vx_mem_arb_pkg holds:
  - the arb_idx_t typedef (LOG_NUM_REQS bits);
  - a localparam for tag-index placement (LSB);
  - a function to extract the index from a tag.
- Sub-module vx_rr_arbiter: request vector in, one-hot + encoded grant out, with enable-to-advance input. Reusable elsewhere.

Test Plan:
- Reset, then all req_in_valid=0 for 5 cycles -> req_out_valid=0, req_in_ready=0000.
- NUM_REQS=4, all valid continuously, req_out_ready=1 -> grants 0,1,2,3,0; req_out_tag LSBs match; tag = {req_in_tag, idx}.
- Req 2 valid, req_out_ready=0 for 3 cycles, req 0 raises valid in cycle 2 -> grant stays 2 and payload stable; after accept, req 0 is granted next.
- rsp_in_valid=1, tag=0x0B3 (idx=3), rsp_out_ready=1000 -> rsp_out_valid=1000, rsp_out_tag=0x2C, rsp_in_ready=1. With rsp_out_ready[3]=0 -> rsp_in_ready=0.
- Assert reset while req 1 is stalled at the output -> next cycle req_out_valid=0, rr_ptr=0; after release, req 1 is re-granted.
- With VX_MEM_ARB_OUT_BUF_EN and req_out_ready toggling 1/0 -> no loss or duplication over 100 random transfers; first req_out_valid one cycle after the upstream transfer.
